jury_vote_sequencer: RTL
========================

Name: jury_vote_sequencer

Overview:
Sequences the jury entry encoder (2-bit juror code J -> {S1,S0}) so several jurors can share it. Round-robin arbitration grants one pending juror at a time: the controller drives the juror's code onto the encoder, samples the result, acks the juror and tallies the vote. When every juror has voted, or the voting window times out, it issues a verdict. It sits between the juror input panel and the verdict display logic.

Parameters:
NJ, 4, number of jurors (2..8)
TIMEOUT, 255, voting-window length in clk cycles after start (1..65535)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
start  input  1  one-cycle pulse; opens the voting window (ignored unless IDLE)
vote_valid  input  NJ  juror i has a vote pending
vote_code  input  2*NJ  juror i code at [2i+1:2i]; held stable while vote_valid[i]=1
vote_ack  output  NJ  one-hot, one-cycle pulse; juror i's vote consumed
enc_j  output  2  code driven to the shared entry encoder J input
enc_s1  input  1  encoder output S1 (combinational from enc_j)
enc_s0  input  1  encoder output S0
approve_cnt  output  4  approve votes counted
reject_cnt  output  4  reject votes counted
busy  output  1  window open (state not IDLE/DONE)
done  output  1  one-cycle pulse when verdict becomes valid
verdict  output  2  00 none, 01 approved, 10 rejected, 11 tie/no decision

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE. vote_ack=0, enc_j=0, approve_cnt=0, reject_cnt=0, busy=0, done=0, verdict=00, rr_ptr=0, voted mask=0, timer=0. Reset overrides everything, including mid-window.
- Encoder result decode: {S1,S0}=01 approve, 10 reject, 00 empty (no count), 11 invalid (no count, juror still marked voted).
- States:
  - IDLE: on start -> ARB. Clear counters, voted mask and verdict; timer=0.
  - ARB: eligible = vote_valid & ~voted. If none eligible, stay. Otherwise grant the first eligible index at or after rr_ptr (wrapping NJ-1 -> 0), latch its code into enc_j -> SAMPLE.
  - SAMPLE: one cycle; the encoder settles on the registered enc_j. At the end of the cycle, register {enc_s1,enc_s0}, pulse vote_ack[g], set voted[g], update the count, rr_ptr = g+1 mod NJ -> ARB. Otherwise voted mask is all ones -> DECIDE.
  - DECIDE: verdict = 01 if approve>reject, 10 if reject>approve, else 11. Pulse done -> DONE.
  - DONE: hold verdict and counters. busy=0. start -> ARB (fresh window, same clears as from IDLE).
- Latency: 2 cycles per vote (ARB grant, SAMPLE). vote_ack asserts on the cycle after the grant.
- Timer: increments every cycle while busy. When timer reaches TIMEOUT-1, the next state is DECIDE from either ARB or SAMPLE. A vote in SAMPLE on that same cycle is still counted and acked before deciding.
- Each juror is counted at most once per window. A juror still holding vote_valid after its ack is ignored.
- Counters saturate at 15 and never wrap.
- start while busy: ignored.
- enc_j returns to 0 outside SAMPLE.

Optional Feature:
TIE_BREAK_EN
- Defined: in DECIDE, a tie (approve==reject) with juror 0 voted and decoded approve/reject gives verdict = juror 0's vote (01/10). 11 only if juror 0 did not vote validly.
- Undefined: a tie always gives verdict 11. The juror-0 result register is not built.

Test Plan:
- Reset mid-window: start, grant juror 1, assert rst during SAMPLE -> next cycle all outputs 0, state IDLE, no vote_ack.
- NJ=4, all valid, codes 1,1,2,1 -> acks in order 0,1,2,3 on cycles 2,4,6,8 after start. approve_cnt=3, reject_cnt=1, verdict=01, done pulse once.
- Round-robin fairness: juror 0 votes first, then jurors 3 and 1 assert vote_valid together -> juror 1 is granted before juror 3. Juror 0's persisting valid gets no second ack.
- Timeout: TIMEOUT=20, only juror 2 votes (code 2) -> done 20 cycles after start, reject_cnt=1, verdict=10.
- Tie: codes 1,2,1,2 -> verdict 11 without TIE_BREAK_EN. With it, verdict 01 (juror 0 approved).
- Invalid/empty codes 3 and 0 from jurors 0 and 1, jurors 2 and 3 code 2 -> all four acked, reject_cnt=2, approve_cnt=0, verdict=10. start pulse while busy has no effect.

Source files
------------

// File: rtl/jury_vote_sequencer_if.sv
// Juror panel / shared entry encoder signals of jury_vote_sequencer.
// The master modport is the sequencer's view; slave is the panel and encoder side.
interface jury_vote_sequencer_if #(
  parameter int NJ = 4
);
  logic [NJ-1:0]   vote_valid;
  logic [2*NJ-1:0] vote_code;
  logic [NJ-1:0]   vote_ack;
  logic [1:0]      enc_j;
  logic            enc_s1;
  logic            enc_s0;

  modport master (
    input  vote_valid,
    input  vote_code,
    input  enc_s1,
    input  enc_s0,
    output vote_ack,
    output enc_j
  );

  modport slave (
    output vote_valid,
    output vote_code,
    output enc_s1,
    output enc_s0,
    input  vote_ack,
    input  enc_j
  );
endinterface

// File: rtl/jury_vote_sequencer.sv
// Round-robin sequencer sharing one jury entry encoder among NJ jurors; tallies votes and issues a verdict.
// Optional macro TIE_BREAK_EN: a tie is resolved by juror 0's valid vote.
module jury_vote_sequencer #(
  parameter int NJ      = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  jury_vote_sequencer_if.master bus,
  output logic [3:0]           approve_cnt,
  output logic [3:0]           reject_cnt,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           verdict
);

  localparam int PW = (NJ > 1) ? $clog2(NJ) : 1;

  localparam logic [1:0] RES_APPROVE = 2'b01;
  localparam logic [1:0] RES_REJECT  = 2'b10;
  localparam logic [1:0] V_APPROVED  = 2'b01;
  localparam logic [1:0] V_REJECTED  = 2'b10;
  localparam logic [1:0] V_TIE       = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_SAMPLE,
    S_DECIDE,
    S_DONE
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   grant;
  logic [NJ-1:0]   voted;
  logic [15:0]     timer;
  logic [1:0]      verdict_q;

  logic [NJ-1:0]   eligible;
  logic [NJ-1:0]   grant_mask;
  logic            found;
  logic [PW-1:0]   pick;
  logic            timeout_hit;
  logic            open_window;
  logic [1:0]      result;
  logic [1:0]      tie_verdict;
  logic [1:0]      verdict_calc;

  assign result      = {bus.enc_s1, bus.enc_s0};
  assign grant_mask  = NJ'(1) << grant;
  assign timeout_hit = (timer == 16'(TIMEOUT - 1));
  assign open_window = start && (state == S_IDLE || state == S_DONE);

  // Round-robin search: first eligible juror at or after rr_ptr, wrapping.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    eligible = bus.vote_valid & ~voted;
    found    = 1'b0;
    pick     = '0;
    for (int off = 0; off < NJ; off++) begin
      if (!found && eligible[(int'(rr_ptr) + off) % NJ]) begin
        found = 1'b1;
        pick  = PW'((int'(rr_ptr) + off) % NJ);
      end
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:   if (start) next_state = S_ARB;
      S_ARB: begin
        if (timeout_hit)  next_state = S_DECIDE;
        else if (found)   next_state = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (timeout_hit || (&(voted | grant_mask))) next_state = S_DECIDE;
        else                                        next_state = S_ARB;
      end
      S_DECIDE: next_state = S_DONE;
      S_DONE:   if (start) next_state = S_ARB;
      default:  next_state = S_IDLE;
    endcase
  end

`ifdef TIE_BREAK_EN
  logic [1:0] j0_res;

  // Juror 0's decoded result for this window; 00 until juror 0 has been sampled.
  always_ff @(posedge clk) begin
    if (rst)                                j0_res <= '0;
    else if (open_window)                   j0_res <= '0;
    else if (state == S_SAMPLE && grant == '0) j0_res <= result;
  end

  assign tie_verdict = (j0_res == RES_APPROVE || j0_res == RES_REJECT) ? j0_res : V_TIE;
`else
  assign tie_verdict = V_TIE;
`endif

  always_comb begin
    verdict_calc = tie_verdict;
    if (approve_cnt > reject_cnt)      verdict_calc = V_APPROVED;
    else if (reject_cnt > approve_cnt) verdict_calc = V_REJECTED;
  end

  // The verdict is shown combinationally during DECIDE so it is valid with the done pulse.
  assign busy    = (state == S_ARB) || (state == S_SAMPLE) || (state == S_DECIDE);
  assign done    = (state == S_DECIDE);
  assign verdict = done ? verdict_calc : verdict_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      rr_ptr       <= '0;
      grant        <= '0;
      voted        <= '0;
      timer        <= '0;
      approve_cnt  <= '0;
      reject_cnt   <= '0;
      verdict_q    <= '0;
      bus.vote_ack <= '0;
      bus.enc_j    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state        <= next_state;
      bus.vote_ack <= '0;
      if (busy) timer <= timer + 16'd1;

      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            voted       <= '0;
            timer       <= '0;
            approve_cnt <= '0;
            reject_cnt  <= '0;
            verdict_q   <= '0;
          end
        end
        S_ARB: begin
          if (!timeout_hit && found) begin
            grant     <= pick;
            bus.enc_j <= bus.vote_code[2*pick +: 2];
          end
        end
        S_SAMPLE: begin
          bus.vote_ack <= grant_mask;
          bus.enc_j    <= '0;
          voted        <= voted | grant_mask;
          rr_ptr       <= (int'(grant) == NJ - 1) ? '0 : grant + 1'b1;
          if (result == RES_APPROVE && approve_cnt != 4'hF) approve_cnt <= approve_cnt + 4'd1;
          if (result == RES_REJECT  && reject_cnt  != 4'hF) reject_cnt  <= reject_cnt + 4'd1;
        end
        S_DECIDE: verdict_q <= verdict_calc;
        default: ;
      endcase
    end
  end

  a_ack_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(bus.vote_ack));
  a_enc_idle:   assert property (@(posedge clk) disable iff (rst)
                                 (state != S_SAMPLE) |-> (bus.enc_j == 2'b00));

endmodule
